// File: rtl/fsc_pkg.sv
// Shared types and constants for the fault syndrome collector.
// The MISR polynomial and seed are used only when FSC_MISR_EN is defined.
package fsc_pkg;

  typedef enum logic [1:0] {
    FSC_IDLE    = 2'd0,
    FSC_COLLECT = 2'd1,
    FSC_REPORT  = 2'd2
  } fsc_state_e;

  // Feedback taps, LSB-aligned; a compactor of width W uses the low W bits.
  localparam logic [63:0] FSC_MISR_POLY = 64'h0000_0000_0000_001B;
  localparam logic [63:0] FSC_MISR_SEED = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/fsc_misr.sv
// Multiple-input signature register that compacts the per-pattern golden^faulty
// difference. Built into the collector only when FSC_MISR_EN is defined.
module fsc_misr
  import fsc_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [OUT_W-1:0] data,
  output logic [OUT_W-1:0] signature
);

  localparam logic [OUT_W-1:0] POLY = FSC_MISR_POLY[OUT_W-1:0];
  localparam logic [OUT_W-1:0] SEED = FSC_MISR_SEED[OUT_W-1:0];

  logic [OUT_W-1:0] sig_next;

  // Galois step: shift left, fold the carried-out MSB through the taps, add input.
  always_comb begin
    sig_next = {signature[OUT_W-2:0], 1'b0} ^ data;
    if (signature[OUT_W-1]) begin
      sig_next = sig_next ^ POLY;
    end else begin
      sig_next = sig_next;
    end
  end

  // Signature register: seeded on session start, advanced on each accepted pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signature <= {OUT_W{1'b0}};
    end else if (load) begin
      signature <= SEED;
    end else if (shift) begin
      signature <= sig_next;
    end else begin
      signature <= signature;
    end
  end

endmodule

// File: rtl/fault_syndrome_collector.sv
// Records per-pattern golden/faulty mismatches of one fault session and reports them.
// Define FSC_MISR_EN to build the signature compactor; otherwise signature is tied to 0.
module fault_syndrome_collector
  import fsc_pkg::*;
#(
  parameter int OUT_W   = 64,
  parameter int PAT_MAX = 129,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pat_valid,
  input  logic               pat_last,
  input  logic [OUT_W-1:0]   golden,
  input  logic [OUT_W-1:0]   faulty,
  input  logic               syn_ready,
  input  logic               clear,
  output logic [PAT_MAX-1:0] syndrome,
  output logic               syn_valid,
  output logic               detected,
  output logic               busy,
  output logic               overflow,
  output logic [CNT_W-1:0]   fault_count,
  output logic [CNT_W-1:0]   det_count,
  output logic [OUT_W-1:0]   signature
);

  localparam int IDX_W = $clog2(PAT_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PAT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  fsc_state_e         state, state_next;
  logic [IDX_W-1:0]   index;
  logic [PAT_MAX-1:0] syndrome_next;
  logic               mismatch;
  logic               take_start;
  logic               take_pat;
  logic               take_report;

  assign mismatch    = (golden != faulty);
  assign take_start  = (state == FSC_IDLE) && start;
  assign take_pat    = (state == FSC_COLLECT) && pat_valid;
  assign take_report = (state == FSC_REPORT) && syn_ready;
  assign syn_valid   = (state == FSC_REPORT);
  assign busy        = (state != FSC_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FSC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a pattern arriving with start in IDLE is dropped.
  always_comb begin
    state_next = state;
    case (state)
      FSC_IDLE: begin
        if (start) state_next = FSC_COLLECT;
        else       state_next = FSC_IDLE;
      end
      FSC_COLLECT: begin
        if (pat_valid && pat_last) state_next = FSC_REPORT;
        else                       state_next = FSC_COLLECT;
      end
      FSC_REPORT: begin
        if (syn_ready) state_next = FSC_REPORT == state ? FSC_IDLE : FSC_REPORT;
        else           state_next = FSC_REPORT;
      end
      default: state_next = FSC_IDLE;
    endcase
  end

  // Write the current mismatch into the slot addressed by index; no slot once full.
  always_comb begin
    syndrome_next = syndrome;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (index == IDX_W'(i)) begin
        syndrome_next[i] = mismatch;
      end else begin
        syndrome_next[i] = syndrome[i];
      end
    end
  end

  // Session record; index saturates at PAT_MAX so later patterns never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syndrome <= {PAT_MAX{1'b0}};
      index    <= {IDX_W{1'b0}};
      detected <= 1'b0;
      overflow <= 1'b0;
    end else if (take_start) begin
      syndrome <= {PAT_MAX{1'b0}};
      index    <= {IDX_W{1'b0}};
      detected <= 1'b0;
      overflow <= 1'b0;
    end else if (take_pat) begin
      syndrome <= syndrome_next;
      detected <= detected | mismatch;
      if (index == IDX_FULL) begin
        overflow <= 1'b1;
      end else begin
        index <= index + IDX_W'(1);
      end
    end else begin
      syndrome <= syndrome;
      detected <= detected;
    end
  end

  // Saturating session counters; clear outranks a concurrent report handshake.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      fault_count <= {CNT_W{1'b0}};
      det_count   <= {CNT_W{1'b0}};
    end else if (take_report) begin
      if (fault_count != CNT_SAT) fault_count <= fault_count + CNT_W'(1);
      else                        fault_count <= fault_count;
      if (detected && det_count != CNT_SAT) det_count <= det_count + CNT_W'(1);
      else                                  det_count <= det_count;
    end else begin
      fault_count <= fault_count;
      det_count   <= det_count;
    end
  end

`ifdef FSC_MISR_EN
  fsc_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (take_start),
    .shift     (take_pat),
    .data      (golden ^ faulty),
    .signature (signature)
  );
`else
  assign signature = {OUT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fault_syndrome_collector.sv
// Directed self-checking bench for fault_syndrome_collector (small PAT_MAX/CNT_W so
// overflow and counter saturation are reachable). Honours FSC_MISR_EN if defined.
module tb_fault_syndrome_collector;

  localparam int OUT_W   = 8;
  localparam int PAT_MAX = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               pat_valid = 1'b0;
  logic               pat_last = 1'b0;
  logic [OUT_W-1:0]   golden = 8'h00;
  logic [OUT_W-1:0]   faulty = 8'h00;
  logic               syn_ready = 1'b0;
  logic               clear = 1'b0;
  logic [PAT_MAX-1:0] syndrome;
  logic               syn_valid, detected, busy, overflow;
  logic [CNT_W-1:0]   fault_count, det_count;
  logic [OUT_W-1:0]   signature;

  int n_cmp = 0;
  int n_bad = 0;

  fault_syndrome_collector #(.OUT_W(OUT_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_last(pat_last),
    .golden(golden), .faulty(faulty), .syn_ready(syn_ready), .clear(clear),
    .syndrome(syndrome), .syn_valid(syn_valid), .detected(detected), .busy(busy),
    .overflow(overflow), .fault_count(fault_count), .det_count(det_count),
    .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pat(input logic [7:0] g, input logic [7:0] f, input logic last);
    golden = g; faulty = f; pat_last = last; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0; pat_last = 1'b0;
  endtask

  task automatic open_session();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic handshake();
    syn_ready = 1'b1;
    step();
    syn_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    n_cmp++; if (syn_valid !== 1'b0) begin n_bad++; $display("FAIL reset_syn_valid got %b want 0", syn_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (syndrome !== 4'b0000) begin n_bad++; $display("FAIL reset_syndrome got %b want 0000", syndrome); end
    n_cmp++; if ({detected, overflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {detected, overflow}); end
    n_cmp++; if ({fault_count, det_count} !== 4'h0) begin n_bad++; $display("FAIL reset_counts got %h want 0", {fault_count, det_count}); end
    n_cmp++; if (signature !== 8'h00) begin n_bad++; $display("FAIL reset_signature got %h want 00", signature); end
  endtask

  task automatic test_detect();
    open_session();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL det_busy got %b want 1", busy); end
    send_pat(8'h11, 8'h11, 1'b0);
    send_pat(8'h22, 8'h22, 1'b0);
    send_pat(8'h33, 8'h37, 1'b0);
    send_pat(8'h44, 8'h44, 1'b1);
    n_cmp++; if (syn_valid !== 1'b1) begin n_bad++; $display("FAIL det_syn_valid got %b want 1", syn_valid); end
    n_cmp++; if (syndrome !== 4'b0100) begin n_bad++; $display("FAIL det_syndrome got %b want 0100", syndrome); end
    n_cmp++; if ({detected, overflow} !== 2'b10) begin n_bad++; $display("FAIL det_flags got %b want 10", {detected, overflow}); end
    handshake();
    n_cmp++; if ({syn_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL det_idle got %b want 00", {syn_valid, busy}); end
    n_cmp++; if (fault_count !== 2'd1 || det_count !== 2'd1) begin n_bad++; $display("FAIL det_counts got %0d/%0d want 1/1", fault_count, det_count); end
  endtask

  task automatic test_clean();
    open_session();
    send_pat(8'hA5, 8'hA5, 1'b0);
    send_pat(8'h5A, 8'h5A, 1'b0);
    send_pat(8'hFF, 8'hFF, 1'b1);
    n_cmp++; if (syndrome !== 4'b0000) begin n_bad++; $display("FAIL clean_syndrome got %b want 0000", syndrome); end
    n_cmp++; if (detected !== 1'b0) begin n_bad++; $display("FAIL clean_detected got %b want 0", detected); end
    handshake();
    n_cmp++; if (fault_count !== 2'd2 || det_count !== 2'd1) begin n_bad++; $display("FAIL clean_counts got %0d/%0d want 2/1", fault_count, det_count); end
  endtask

  task automatic test_overflow();
    open_session();
    for (int i = 0; i < 6; i++) begin
      send_pat(8'h10, (i == 5) ? 8'h18 : 8'h10, (i == 5));
    end
    n_cmp++; if (syn_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_syn_valid got %b want 1", syn_valid); end
    n_cmp++; if (syndrome !== 4'b0000) begin n_bad++; $display("FAIL ovf_syndrome got %b want 0000", syndrome); end
    n_cmp++; if ({detected, overflow} !== 2'b11) begin n_bad++; $display("FAIL ovf_flags got %b want 11", {detected, overflow}); end
    handshake();
    n_cmp++; if (fault_count !== 2'd3 || det_count !== 2'd2) begin n_bad++; $display("FAIL ovf_counts got %0d/%0d want 3/2", fault_count, det_count); end
  endtask

  task automatic test_hold();
    open_session();
    n_cmp++; if ({detected, overflow} !== 2'b00) begin n_bad++; $display("FAIL hold_entry_flags got %b want 00", {detected, overflow}); end
    send_pat(8'h00, 8'h80, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      start = 1'b0;
      n_cmp++; if (syn_valid !== 1'b1 || syndrome !== 4'b0001 || detected !== 1'b1) begin
        n_bad++; $display("FAIL hold_stable cyc %0d got v=%b s=%b d=%b want v=1 s=0001 d=1", i, syn_valid, syndrome, detected);
      end
    end
    handshake();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_start_ignored busy got %b want 0", busy); end
    n_cmp++; if (fault_count !== 2'd3 || det_count !== 2'd3) begin n_bad++; $display("FAIL hold_sat_counts got %0d/%0d want 3/3", fault_count, det_count); end
  endtask

  task automatic test_clear_wins();
    open_session();
    send_pat(8'h01, 8'h02, 1'b1);
    clear = 1'b1;
    handshake();
    clear = 1'b0;
    n_cmp++; if (fault_count !== 2'd0 || det_count !== 2'd0) begin n_bad++; $display("FAIL clear_counts got %0d/%0d want 0/0", fault_count, det_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clear_idle busy got %b want 0", busy); end
  endtask

  task automatic test_start_with_pat();
    golden = 8'h00; faulty = 8'hFF; pat_valid = 1'b1; pat_last = 1'b1; start = 1'b1;
    step();
    start = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
    n_cmp++; if ({busy, syn_valid} !== 2'b10) begin n_bad++; $display("FAIL swp_state got %b want 10", {busy, syn_valid}); end
    n_cmp++; if (syndrome !== 4'b0000) begin n_bad++; $display("FAIL swp_syndrome_clear got %b want 0000", syndrome); end
    send_pat(8'h00, 8'h00, 1'b0);
    send_pat(8'h00, 8'h40, 1'b1);
    n_cmp++; if (syndrome !== 4'b0010) begin n_bad++; $display("FAIL swp_syndrome got %b want 0010", syndrome); end
    handshake();
    n_cmp++; if (fault_count !== 2'd1 || det_count !== 2'd1) begin n_bad++; $display("FAIL swp_counts got %0d/%0d want 1/1", fault_count, det_count); end
  endtask

  task automatic test_misr();
    logic [7:0] exp2, exp3;
`ifdef FSC_MISR_EN
    exp2 = 8'h82;  // 0 -> 0x01 -> (0x01<<1)^0x80
    exp3 = 8'h1F;  // MSB set: (0x82<<1)^0x1B^0x00
`else
    exp2 = 8'h00;
    exp3 = 8'h00;
`endif
    open_session();
    n_cmp++; if (signature !== 8'h00) begin n_bad++; $display("FAIL misr_seed got %h want 00", signature); end
    send_pat(8'h00, 8'h01, 1'b0);
    send_pat(8'hFF, 8'h7F, 1'b0);
    n_cmp++; if (signature !== exp2) begin n_bad++; $display("FAIL misr_two got %h want %h", signature, exp2); end
    send_pat(8'h3C, 8'h3C, 1'b1);
    n_cmp++; if (signature !== exp3) begin n_bad++; $display("FAIL misr_three got %h want %h", signature, exp3); end
    handshake();
    n_cmp++; if (signature !== exp3 || syndrome !== 4'b0011) begin n_bad++; $display("FAIL misr_after got sig=%h syn=%b want sig=%h syn=0011", signature, syndrome, exp3); end
    send_pat(8'h00, 8'hFF, 1'b1);
    n_cmp++; if (busy !== 1'b0 || syndrome !== 4'b0011 || fault_count !== 2'd2) begin
      n_bad++; $display("FAIL idle_pat_ignored got busy=%b syn=%b fc=%0d want 0/0011/2", busy, syndrome, fault_count);
    end
  endtask

  task automatic test_reset_mid();
    open_session();
    send_pat(8'h00, 8'h01, 1'b0);
    send_pat(8'h00, 8'h00, 1'b0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_cmp++; if ({busy, syn_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_state got %b want 00", {busy, syn_valid}); end
    n_cmp++; if (syndrome !== 4'b0000 || detected !== 1'b0) begin n_bad++; $display("FAIL rmid_syndrome got %b/%b want 0000/0", syndrome, detected); end
    n_cmp++; if (fault_count !== 2'd0 || det_count !== 2'd0) begin n_bad++; $display("FAIL rmid_counts got %0d/%0d want 0/0", fault_count, det_count); end
    open_session();
    send_pat(8'h00, 8'h00, 1'b0);
    n_cmp++; if (syndrome !== 4'b0000) begin n_bad++; $display("FAIL rmid_fresh got %b want 0000", syndrome); end
  endtask

  initial begin
    test_reset();
    test_detect();
    test_clean();
    test_overflow();
    test_hold();
    test_clear_wins();
    test_start_with_pat();
    test_misr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fault_syndrome_collector.md
FAULT_SYNDROME_COLLECTOR -- requirements
Module: fault_syndrome_collector

Interface
REQ-001 SHALL have parameter OUT_W, default 64, width of the compared output vectors.
REQ-002 SHALL have parameter PAT_MAX, default 129, syndrome length (max patterns per fault).
REQ-003 SHALL have parameter CNT_W, default 16, width of the fault and detected counters.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  pulse, opens a new fault session.
REQ-007 SHALL have port pat_valid  input  1  golden/faulty pair valid this cycle.
REQ-008 SHALL have port pat_last  input  1  qualifies the final pattern of the session.
REQ-009 SHALL have ports golden and faulty  input  OUT_W  good-machine and faulty-machine outputs.
REQ-010 SHALL have port syn_ready  input  1  consumer accepts the report.
REQ-011 SHALL have port clear  input  1  zeroes fault_count and det_count.
REQ-012 SHALL have port syndrome  output  PAT_MAX  bit i = 1 iff pattern i mismatched.
REQ-013 SHALL have ports syn_valid, detected, busy, overflow  output  1 each.
REQ-014 SHALL have ports fault_count and det_count  output  CNT_W  sessions reported / sessions detected.
REQ-015 SHALL have port signature  output  OUT_W  MISR signature of the session (see REQ-030).

Function
REQ-016 SHALL implement FSM IDLE -> COLLECT on start; COLLECT -> REPORT on accepted pat_valid with pat_last; REPORT -> IDLE on syn_ready.
REQ-017 On entry to COLLECT, SHALL clear syndrome, pattern index, detected, overflow and signature in the same cycle.
REQ-018 In COLLECT, each pat_valid SHALL write (golden != faulty) into syndrome[index], visible next cycle, then increment index.
REQ-019 detected SHALL be the OR of all mismatches in the session, including mismatches beyond PAT_MAX.
REQ-020 Pattern index reaching PAT_MAX SHALL set overflow (sticky for the session); later patterns SHALL leave syndrome unchanged, with no wrap-around.
REQ-021 syn_valid SHALL be 1 exactly while in REPORT; syndrome, detected and signature SHALL hold stable while in REPORT.
REQ-022 On syn_valid and syn_ready, fault_count SHALL increment by 1 and det_count by 1 if detected; both counters SHALL saturate at all-ones.
REQ-023 busy SHALL be 1 in COLLECT and REPORT.
REQ-024 start outside IDLE, and pat_valid outside COLLECT, SHALL be ignored.
REQ-025 If clear coincides with a REPORT handshake, clear SHALL win and the counters SHALL read 0.
REQ-026 If start and a single pat_valid with pat_last arrive together in IDLE, only start SHALL be taken.

Reset
REQ-027 rst_n = 0 at a clock edge SHALL force IDLE and zero all outputs and counters, including mid-COLLECT and mid-REPORT.
REQ-028 Reset SHALL take priority over start, clear and syn_ready.

Configuration
REQ-029 Macro FSC_MISR_EN SHALL compile in the signature compactor.
REQ-030 With FSC_MISR_EN defined, each accepted pattern SHALL shift (golden ^ faulty) into an OUT_W MISR using package polynomial FSC_MISR_POLY, seeded with 0 on session start.
REQ-031 Without FSC_MISR_EN, signature SHALL be constant 0 and no MISR flops SHALL be inferred.

Structure
REQ-032 Package fsc_pkg SHALL hold the FSM state enum, FSC_MISR_POLY and its default seed.
REQ-033 The MISR SHALL be sub-module fsc_misr (parameter OUT_W), instantiated only under FSC_MISR_EN.

Verification
REQ-034 Four patterns with mismatch only on pattern 2, then syn_ready -> syndrome = 0b0100, detected = 1, fault_count = 1, det_count = 1.
REQ-035 Three equal patterns -> syndrome = 0, detected = 0, det_count unchanged, fault_count incremented.
REQ-036 PAT_MAX = 4 with 6 patterns, mismatch on pattern 5 only -> overflow = 1, syndrome = 0, detected = 1.
REQ-037 rst_n held low for 1 cycle mid-COLLECT after 2 patterns -> IDLE, syndrome = 0, busy = 0, counters = 0.
REQ-038 syn_ready held low 5 cycles in REPORT with start pulsed -> syn_valid held, outputs stable, start ignored.
REQ-039 FSC_MISR_EN on, OUT_W = 8, two patterns with XOR 0x01 then 0x80 -> signature matches reference-model MISR; with the macro off -> signature = 0x00.
